// File: rtl/chacha_stream.sv
// chacha_stream: register-mapped ChaCha keystream engine with block sequencer and word FIFO.
// Core state layout: word12 = ctr[31:0], word13 = ctr[63:32] ^ nonce MSW, words 14/15 = rest of nonce.

module chacha_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [63:0]  ctr,
    input  logic [4:0]   rounds,
    input  logic [511:0] data_in,
    output logic         ready,
    output logic         data_out_valid,
    output logic [511:0] data_out
);
    typedef logic [15:0][31:0] st_t;

    st_t         s0, x, ist;
    logic [4:0]  cnt;
    logic        running;
    logic [511:0] out_c;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] w, input int unsigned n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic st_t qr(input st_t s, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        st_t t = s;
        t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 16);
        t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 12);
        t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 8);
        t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 7);
        return t;
    endfunction

    // Even round index: column round; odd: diagonal round.
    function automatic st_t dround(input st_t s, input logic diag);
        st_t t = s;
        if (!diag) begin
            t = qr(t, 4'd0, 4'd4, 4'd8,  4'd12);
            t = qr(t, 4'd1, 4'd5, 4'd9,  4'd13);
            t = qr(t, 4'd2, 4'd6, 4'd10, 4'd14);
            t = qr(t, 4'd3, 4'd7, 4'd11, 4'd15);
        end else begin
            t = qr(t, 4'd0, 4'd5, 4'd10, 4'd15);
            t = qr(t, 4'd1, 4'd6, 4'd11, 4'd12);
            t = qr(t, 4'd2, 4'd7, 4'd8,  4'd13);
            t = qr(t, 4'd3, 4'd4, 4'd9,  4'd14);
        end
        return t;
    endfunction

    // next continues from the previous block with the low counter word advanced.
    always_comb begin
        ist     = '0;
        ist[0]  = 32'h61707865;
        ist[1]  = 32'h3320646e;
        ist[2]  = 32'h79622d32;
        ist[3]  = 32'h6b206574;
        for (int i = 0; i < 8; i++) ist[4+i] = bswap(key[32*(7-i) +: 32]);
        ist[12] = ctr[31:0];
        ist[13] = ctr[63:32] ^ bswap(nonce[95:64]);
        ist[14] = bswap(nonce[63:32]);
        ist[15] = bswap(nonce[31:0]);
        if (!init) begin
            ist     = s0;
            ist[12] = s0[12] + 32'd1;
        end
    end

    always_comb begin
        out_c = '0;
        for (int i = 0; i < 16; i++)
            out_c[32*(15-i) +: 32] = bswap(x[i] + s0[i]) ^ data_in[32*(15-i) +: 32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0             <= '0;
            x              <= '0;
            cnt            <= '0;
            running        <= 1'b0;
            ready          <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else if (init || next) begin
            s0             <= ist;
            x              <= ist;
            cnt            <= '0;
            running        <= 1'b1;
            ready          <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (running) begin
            if (cnt == rounds) begin
                data_out       <= out_c;
                running        <= 1'b0;
                ready          <= 1'b1;
                data_out_valid <= 1'b1;
            end else begin
                x   <= dround(x, cnt[0]);
                cnt <= cnt + 5'd1;
            end
        end
    end
endmodule

module chacha_stream #(
    parameter int unsigned CTR_WIDTH  = 64,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [63:0] CTR_MAX = (CTR_WIDTH == 32) ? 64'h0000_0000_ffff_ffff : '1;

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, PUSH, NEXT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   key_q [8];
    logic [31:0]   iv_q [3];
    logic [31:0]   din_q [16];
    logic [31:0]   mem [FIFO_DEPTH];
    logic [63:0]   ctr_q;
    logic [4:0]    rounds_q;
    logic [1:0]    irq_en_q;
    logic          auto_q, done_q, wrap_q, unf_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [3:0]    wcnt;

    logic          wr_c, rd_c, pop_c, unf_c, busy_c, room_c, start_c, clr_c, empty_c, full_c;
    logic          push_c, blk_done_c, wrap_c, step_c;
    logic [31:0]   push_word;
    logic [255:0]  core_key;
    logic [95:0]   core_nonce;
    logic [511:0]  core_din, core_dout;
    logic          core_ready, core_valid;

    assign wr_c    = cs & we;
    assign rd_c    = cs & ~we;
    assign empty_c = (level == '0);
    assign full_c  = (level == LW'(FIFO_DEPTH));
    assign pop_c   = rd_c && (addr == 8'h80) && !empty_c;
    assign unf_c   = rd_c && (addr == 8'h80) && empty_c;
    assign busy_c  = (state != IDLE);
    assign room_c  = (LW'(FIFO_DEPTH) - level) >= LW'(16);
    assign start_c = wr_c && (addr == 8'h08) && write_data[0];
    assign clr_c   = wr_c && (addr == 8'h08) && write_data[2] && !busy_c;
    assign irq     = (done_q & irq_en_q[0]) | (wrap_q & irq_en_q[1]);

    always_comb begin
        core_key   = '0;
        core_nonce = '0;
        core_din   = '0;
        push_word  = '0;
        for (int i = 0; i < 8; i++)  core_key[32*(7-i) +: 32]  = key_q[i];
        for (int i = 0; i < 3; i++)  core_nonce[32*(2-i) +: 32] = iv_q[i];
        for (int i = 0; i < 16; i++) core_din[32*(15-i) +: 32] = din_q[i];
        for (int i = 0; i < 16; i++) if (wcnt == 4'(i)) push_word = core_dout[32*(15-i) +: 32];
    end

    chacha_core u_core (
        .clk            (clk),
        .reset_n        (reset_n),
        .init           (state == ISSUE),
        .next           (1'b0),
        .key            (core_key),
        .nonce          (core_nonce),
        .ctr            (ctr_q),
        .rounds         (rounds_q),
        .data_in        (core_din),
        .ready          (core_ready),
        .data_out_valid (core_valid),
        .data_out       (core_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= (state == PUSH) ? wcnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt  = state;
        push_c     = 1'b0;
        blk_done_c = 1'b0;
        wrap_c     = 1'b0;
        step_c     = 1'b0;
        case (state)
            IDLE:  if ((start_c || auto_q) && room_c) state_nxt = ISSUE;
            ISSUE: state_nxt = ARM;
            ARM:   state_nxt = WAIT;
            WAIT:  if (core_ready && core_valid) state_nxt = PUSH;
            PUSH: begin
                push_c = 1'b1;
                if (wcnt == 4'd15) begin
                    blk_done_c = 1'b1;
                    state_nxt  = NEXT;
                end
            end
            NEXT: begin
                if (ctr_q == CTR_MAX) begin
                    wrap_c    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    step_c    = 1'b1;
                    state_nxt = (auto_q && room_c) ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration, counter and sticky status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++)  key_q[i] <= '0;
            for (int i = 0; i < 3; i++)  iv_q[i]  <= '0;
            for (int i = 0; i < 16; i++) din_q[i] <= '0;
            ctr_q    <= '0;
            rounds_q <= '0;
            irq_en_q <= '0;
            auto_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_c && !busy_c) begin
                case (addr)
                    8'h0b: rounds_q <= write_data[4:0];
                    8'h0c: ctr_q[31:0] <= write_data;
                    8'h0d: if (CTR_WIDTH == 64) ctr_q[63:32] <= write_data;
                    8'h20: iv_q[0] <= write_data;
                    8'h21: iv_q[1] <= write_data;
                    8'h22: iv_q[2] <= write_data;
                    default: ;
                endcase
                if (addr[7:3] == 5'b00010) key_q[addr[2:0]] <= write_data;
                if (addr[7:4] == 4'h4)     din_q[addr[3:0]] <= write_data;
            end
            if (wr_c && addr == 8'h08) auto_q   <= write_data[1];
            if (wr_c && addr == 8'h0a) irq_en_q <= write_data[1:0];
            if (wr_c && addr == 8'h09) begin
                if (write_data[4]) done_q <= 1'b0;
                if (write_data[5]) wrap_q <= 1'b0;
                if (write_data[6]) unf_q  <= 1'b0;
            end
            if (blk_done_c) done_q <= 1'b1;
            if (unf_c)      unf_q  <= 1'b1;
            if (wrap_c) begin
                wrap_q <= 1'b1;
                auto_q <= 1'b0;
                ctr_q  <= '0;
            end else if (step_c) begin
                ctr_q  <= ctr_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)      level <= level + LW'(1);
            else if (pop_c && !push_c) level <= level - LW'(1);
        end
    end

    always_comb begin
        read_data = '0;
        if (rd_c) begin
            case (addr)
                8'h00: read_data = 32'h63686163;
                8'h01: read_data = 32'h73747265;
                8'h02: read_data = 32'h312e3030;
                8'h08: read_data = {30'h0, auto_q, 1'b0};
                8'h09: read_data = {8'h0, 8'(level), 9'h0, unf_q, wrap_q, done_q,
                                    busy_c, full_c, empty_c, core_ready};
                8'h0a: read_data = {30'h0, irq_en_q};
                8'h0b: read_data = {27'h0, rounds_q};
                8'h0c: read_data = ctr_q[31:0];
                8'h0d: read_data = ctr_q[63:32];
                8'h20: read_data = iv_q[0];
                8'h21: read_data = iv_q[1];
                8'h22: read_data = iv_q[2];
                8'h80: read_data = empty_c ? 32'h0 : mem[rd_ptr];
                default: begin
                    if (addr[7:3] == 5'b00010) read_data = key_q[addr[2:0]];
                    if (addr[7:4] == 4'h4)     read_data = din_q[addr[3:0]];
                end
            endcase
        end
    end
endmodule

// File: doc/chacha_stream.md
# chacha_stream

Streaming ChaCha keystream/cipher engine with a register-mapped bus, parametrised block-counter width and an output word FIFO. It wraps one `chacha_core` instance and adds an autonomous block sequencer that issues blocks with an incrementing counter and pushes the 16 result words into the FIFO. Software drains the FIFO through a single pop address, and a level interrupt reports block completion and counter wrap. It is the next-generation bus front end for the ChaCha datapath.

## Interface
- `CTR_WIDTH`, default 64: block-counter wrap width; legal values are 32 or 64. The core `ctr` input is the counter zero-extended to 64 bits.
- `FIFO_DEPTH`, default 32: output FIFO depth in 32-bit words; a power of 2, at least 16.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs` in 1: bus select.
- `we` in 1: write strobe, qualified by `cs`.
- `addr` in 8: word address.
- `write_data` in 32: write data.
- `read_data` out 32: combinational read data; reads 0 when `cs` is low or during a write.
- `irq` out 1: level interrupt, equal to (done & IRQ_EN[0]) | (wrap & IRQ_EN[1]).

## Operation
- Register map:
  - 0x00 NAME0 = 0x63686163; 0x01 NAME1 = 0x73747265; 0x02 VERSION = 0x312e3030.
  - 0x08 CTRL: bit0 start (pulse, self-clearing); bit1 auto (stored); bit2 fifo_clr (pulse). Reads return {30'h0, auto, 1'b0}.
  - 0x09 STATUS: bit0 core ready; bit1 fifo_empty; bit2 fifo_full; bit3 busy (FSM not in IDLE); bit4 done (sticky); bit5 wrap (sticky); bit6 underflow (sticky). Bits [23:16] hold the FIFO level. Writing 1 to bits 4/5/6 clears that bit.
  - 0x0a IRQ_EN, bits [1:0]. 0x0b ROUNDS, bits [4:0].
  - 0x0c CTR_LO. 0x0d CTR_HI, which reads 0 and ignores writes when CTR_WIDTH=32.
  - 0x10-0x17 KEY0-7; KEY0 is the MSW of the core key.
  - 0x20-0x22 IV0-2; IV0 is the MSW of the core nonce.
  - 0x40-0x4f DATA_IN0-15; DATA_IN0 is the MSW of the core data_in.
  - 0x80 FIFO_POP, read-only.
- Writes to CTR, KEY, IV, ROUNDS and DATA_IN while busy=1 are ignored. fifo_clr while busy=1 is ignored.
- FSM states: IDLE, ISSUE, ARM, WAIT, PUSH, NEXT.
  - IDLE→ISSUE: start=1, or auto=1 with free slots ≥16.
  - ISSUE: drive core init=1 for one cycle with ctr=ctr_reg. Core next is tied to 0.
  - ARM: one guard cycle, so the previous valid/ready state is ignored.
  - WAIT→PUSH: core_ready=1 and data_out_valid=1.
  - PUSH: push words 0..15 (MSW first), one per cycle, over 16 cycles. After the last push, set done=1 and go to NEXT.
  - NEXT: if ctr_reg = 2^CTR_WIDTH−1, then set ctr_reg=0, set wrap=1, clear auto, and go to IDLE. Otherwise ctr_reg += 1; then go to ISSUE if auto=1 and free ≥16, else IDLE.
- Start is accepted only when free ≥16. A start in IDLE with free <16 is dropped.
- FIFO behaviour:
  - A read of 0x80 (cs=1, we=0) returns the head word and pops it, one pop per cycle.
  - A read of 0x80 when empty returns 0, does not pop, and sets underflow.
  - A push and a pop in the same cycle leave the level unchanged.
  - The full/free checks above guarantee no overflow.

## Timing
- Reset values: all registers 0; FSM=IDLE; FIFO empty; read_data=0; irq=0; core init=0.
- A start write at edge t puts the FSM in ISSUE during cycle t+1 (core init high), then ARM at t+2, then WAIT.
- The first FIFO word is visible at 0x80 one cycle after the WAIT→PUSH edge. Word 15 is written 15 cycles later.
- done and wrap rise at the edge leaving PUSH and NEXT respectively. irq follows combinationally.
- In auto mode, back-to-back blocks have no idle cycles: NEXT→ISSUE is immediate.
- If a pop in the last PUSH cycle frees space, that space counts in NEXT.
- Asynchronous reset mid-block:
  - The FSM returns to IDLE and the FIFO empties immediately.
  - Core init deasserts.
  - A subsequent start works normally.

## Test plan
- Reset check: after reset, STATUS=0x00000002 (empty=1), CTRL reads 0, irq=0, and a read of 0x80 returns 0 and sets STATUS bit6.
- Single block: key=0, IV=0, CTR=0, ROUNDS=20, DATA_IN=0; start. The 16 popped words match the golden model (RFC 7539 all-zero vector, bytes 76 b8 e0 ad ...). After the block, done=1 and CTR_LO=1. With IRQ_EN=1, irq=1; writing 0x10 to STATUS drops irq.
- Auto with backpressure: FIFO_DEPTH=32, auto=1, no pops. After exactly 2 blocks the FSM is idle with level=32 and full=1. Popping 16 words restarts the engine, and the third block carries ctr=2.
- Wrap: CTR_WIDTH=32, CTR_LO=0xFFFFFFFF, auto=1. After one block, CTR_LO=0, wrap=1, auto=0, and no further block is issued.
- Busy protection: write KEY0=0xdeadbeef during WAIT. KEY0 keeps its old value, and the output matches the old key.
- Reset mid-PUSH: assert reset_n=0 for 1 cycle after 5 pushes. level=0 and busy=0 immediately; a new start then yields correct output.
